// File: rtl/bsg_fifo_rolly_replay_pkg.sv
// Shared types for the rolly FIFO replay controller.
//   state_e : sequencer state (send, one-cycle rollback, sticky error)
//   resp_s  : one link response as seen by the controller
//   sat_inc16 : saturating 16-bit increment used by the optional statistics
//               counter (enabled with BSG_ROLLY_REPLAY_CTRL_STATS_EN)
package bsg_fifo_rolly_replay_pkg;

  typedef enum logic [1:0] {
    e_send     = 2'd0,
    e_rollback = 2'd1,
    e_error    = 2'd2
  } state_e;

  typedef struct packed {
    logic v;          // response present this cycle
    logic nack;       // 1 = replay request
    logic retire_all; // with an ack: retire every outstanding entry
  } resp_s;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/bsg_fifo_rolly_watchdog.sv
// Response watchdog for the replay controller.
// Counts consecutive enabled cycles; expire pulses on the cycle the count
// reaches timeout_p-1 while enabled, and the count restarts from 0.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   clear          : force the count to 0 (wins over en)
//   en             : count this cycle
//   expire         : timeout reached this cycle
// Neither clear nor en: the count holds.
module bsg_fifo_rolly_watchdog #(
  parameter int timeout_p = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int width_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
  localparam logic [width_lp-1:0] last_lp = width_lp'(timeout_p - 1);

  logic [width_lp-1:0] cnt;

  assign expire = en & ~clear & (cnt == last_lp);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the clock edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt <= '0;
    end else if (clear | expire) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_fifo_rolly_replay_ctrl.sv
// Read-side sequencer for a rollback-capable 1r1w FIFO feeding a lossy link.
// Pops entries speculatively up to window_p, retires them on acks, rewinds the
// FIFO read pointer on a nack or response timeout, and after max_retries_p
// consecutive rewinds without an ack parks in a sticky error state.
//
// Ports:
//   clk_i, reset_i     clock, asynchronous active-high reset (also resets FIFO)
//   fifo_v_i           FIFO has a readable entry at its read pointer
//   fifo_yumi_o        speculative read (advances read pointer)
//   fifo_deq_v_o       retire one entry
//   fifo_ack_v_o       retire every read entry
//   fifo_rollback_v_o  rewind read pointer to the retire pointer
//   link_v_o           entry valid toward the link transmitter
//   link_ready_i       link transmitter accepts
//   resp_v_i, resp_nack_i, resp_all_i   link response (ack/nack, one/all)
//   outstanding_o      read but not yet retired entries
//   error_o            sticky: retries exhausted
//   rollback_cnt_o     saturating rollback count; live only when
//                      BSG_ROLLY_REPLAY_CTRL_STATS_EN is defined, else 0
module bsg_fifo_rolly_replay_ctrl
  import bsg_fifo_rolly_replay_pkg::*;
#(
  parameter int window_p      = 8,
  parameter int timeout_p     = 255,
  parameter int max_retries_p = 3
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           fifo_v_i,
  output logic                           fifo_yumi_o,
  output logic                           fifo_deq_v_o,
  output logic                           fifo_ack_v_o,
  output logic                           fifo_rollback_v_o,
  output logic                           link_v_o,
  input  logic                           link_ready_i,
  input  logic                           resp_v_i,
  input  logic                           resp_nack_i,
  input  logic                           resp_all_i,
  output logic [$clog2(window_p+1)-1:0]  outstanding_o,
  output logic                           error_o,
  output logic [15:0]                    rollback_cnt_o
);

  localparam int cnt_w_lp   = $clog2(window_p + 1);
  localparam int retry_w_lp = $clog2(max_retries_p + 1);
  localparam logic [cnt_w_lp-1:0]   window_lp     = cnt_w_lp'(window_p);
  localparam logic [cnt_w_lp-1:0]   one_lp        = cnt_w_lp'(1);
  localparam logic [retry_w_lp-1:0] retry_last_lp = retry_w_lp'(max_retries_p - 1);

  state_e                state;
  logic [cnt_w_lp-1:0]   outstanding;
  logic [retry_w_lp-1:0] retries;
  resp_s                 resp;

  logic in_send, has_out, resp_live;
  logic ack_one, ack_all, nack, timer_en, expire, rewind, link_v, yumi;

  assign resp = '{v: resp_v_i, nack: resp_nack_i, retire_all: resp_all_i};

  assign in_send   = (state == e_send);
  assign has_out   = (outstanding != '0);
  // Responses only count in SEND with something to retire; otherwise stale.
  assign resp_live = in_send & resp.v & has_out;
  assign ack_one   = resp_live & ~resp.nack & ~resp.retire_all;
  assign ack_all   = resp_live & ~resp.nack &  resp.retire_all;
  assign nack      = resp_live &  resp.nack;

  // Silence on the link only ages while entries are in flight.
  assign timer_en  = in_send & has_out & ~resp.v;

  bsg_fifo_rolly_watchdog #(.timeout_p(timeout_p)) watchdog (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear   (~timer_en),
    .en      (timer_en),
    .expire  (expire)
  );

  assign rewind = nack | expire;

  // The FIFO cannot take a read alongside ack-all or a pending rewind, and the
  // reset term keeps the FIFO idle while the shared reset is held.
  assign link_v = in_send & fifo_v_i & (outstanding < window_lp)
                & ~ack_all & ~rewind & ~reset_i;
  assign yumi   = link_v & link_ready_i;

  assign link_v_o          = link_v;
  assign fifo_yumi_o       = yumi;
  assign fifo_deq_v_o      = ack_one;
  assign fifo_ack_v_o      = ack_all;
  assign fifo_rollback_v_o = (state == e_rollback);
  assign error_o           = (state == e_error);
  assign outstanding_o     = outstanding;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= e_send;
      outstanding <= '0;
      retries     <= '0;
    end else begin
      case (state)
        e_send: begin
          if (rewind) begin
            // Count drops on entry so the rewind cycle already reports 0.
            state       <= e_rollback;
            outstanding <= '0;
          end else if (ack_all) begin
            outstanding <= '0;
            retries     <= '0;
          end else if (ack_one) begin
            outstanding <= outstanding + cnt_w_lp'(yumi) - one_lp;
            retries     <= '0;
          end else begin
            outstanding <= outstanding + cnt_w_lp'(yumi);
          end
        end
        e_rollback: begin
          outstanding <= '0;
          retries     <= retries + 1'b1;
          state       <= (retries == retry_last_lp) ? e_error : e_send;
        end
        e_error: begin
          state <= e_error;
        end
        default: begin
          state <= e_error;
        end
      endcase
    end
  end

`ifdef BSG_ROLLY_REPLAY_CTRL_STATS_EN
  logic [15:0] rollback_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rollback_cnt <= '0;
    end else if (state == e_rollback) begin
      rollback_cnt <= sat_inc16(rollback_cnt);
    end
  end

  assign rollback_cnt_o = rollback_cnt;
`else
  assign rollback_cnt_o = '0;
`endif

  // A response with nothing outstanding means the remote side is confused.
  resp_without_outstanding: assert property (
    @(posedge clk_i) disable iff (reset_i)
      !(in_send && resp_v_i && !has_out)
  ) else $error("response received with no outstanding entries");

endmodule

// File: tb/tb_bsg_fifo_rolly_replay_ctrl.sv
// Directed bench for bsg_fifo_rolly_replay_ctrl with window 4, timeout 16,
// three retries. Inputs change 1 time unit after the rising edge; outputs are
// sampled 3 time units after the edge, well before the next one.
module tb_bsg_fifo_rolly_replay_ctrl;

  localparam int window_lp  = 4;
  localparam int timeout_lp = 16;
  localparam int retries_lp = 3;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        fifo_v_i, link_ready_i, resp_v_i, resp_nack_i, resp_all_i;
  logic        fifo_yumi_o, fifo_deq_v_o, fifo_ack_v_o, fifo_rollback_v_o;
  logic        link_v_o, error_o;
  logic [2:0]  outstanding_o;
  logic [15:0] rollback_cnt_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  bsg_fifo_rolly_replay_ctrl #(
    .window_p      (window_lp),
    .timeout_p     (timeout_lp),
    .max_retries_p (retries_lp)
  ) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .fifo_v_i          (fifo_v_i),
    .fifo_yumi_o       (fifo_yumi_o),
    .fifo_deq_v_o      (fifo_deq_v_o),
    .fifo_ack_v_o      (fifo_ack_v_o),
    .fifo_rollback_v_o (fifo_rollback_v_o),
    .link_v_o          (link_v_o),
    .link_ready_i      (link_ready_i),
    .resp_v_i          (resp_v_i),
    .resp_nack_i       (resp_nack_i),
    .resp_all_i        (resp_all_i),
    .outstanding_o     (outstanding_o),
    .error_o           (error_o),
    .rollback_cnt_o    (rollback_cnt_o)
  );

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef BSG_ROLLY_REPLAY_CTRL_STATS_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic fv, input logic rdy, input logic rv,
                       input logic nk, input logic al);
    fifo_v_i     = fv;
    link_ready_i = rdy;
    resp_v_i     = rv;
    resp_nack_i  = nk;
    resp_all_i   = al;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_link_v"}, 32'(link_v_o), 0);
    check({tag, "_yumi"},   32'(fifo_yumi_o), 0);
    check({tag, "_deq"},    32'(fifo_deq_v_o), 0);
    check({tag, "_ack"},    32'(fifo_ack_v_o), 0);
    check({tag, "_rb"},     32'(fifo_rollback_v_o), 0);
    check({tag, "_out"},    32'(outstanding_o), 0);
  endtask

  initial begin
    int n;
    bit found;

    // Reset held with a readable FIFO: everything stays quiet.
    reset_i = 1'b1;
    drive(1, 1, 0, 0, 0);
    #2;
    check_quiet("reset");
    check("reset_err", 32'(error_o), 0);
    check("reset_cnt", 32'(rollback_cnt_o), 0);
    tick();
    tick();
    reset_i = 1'b0;

    // Fill the window: four yumis, then link_v drops.
    #2;
    check("fill_yumi0", 32'(fifo_yumi_o), 1);
    check("fill_out0", 32'(outstanding_o), 0);
    for (int i = 1; i < window_lp; i++) begin
      tick(); #2;
      check("fill_yumi", 32'(fifo_yumi_o), 1);
      check("fill_out", 32'(outstanding_o), 32'(i));
    end
    tick(); #2;
    check("full_link_v", 32'(link_v_o), 0);
    check("full_out", 32'(outstanding_o), 4);

    // Single ack with a full window: deq now, no read this cycle.
    tick(); drive(1, 1, 1, 0, 0); #2;
    check("ack1_deq", 32'(fifo_deq_v_o), 1);
    check("ack1_yumi", 32'(fifo_yumi_o), 0);
    check("ack1_out", 32'(outstanding_o), 4);

    // Single ack plus read in the same cycle: net change zero.
    tick(); drive(1, 1, 1, 0, 0); #2;
    check("net0_out", 32'(outstanding_o), 3);
    check("net0_deq", 32'(fifo_deq_v_o), 1);
    check("net0_yumi", 32'(fifo_yumi_o), 1);

    // Ack-all with 3 outstanding: ack pulse, link held off.
    tick(); drive(1, 1, 1, 0, 1); #2;
    check("ackall_out_before", 32'(outstanding_o), 3);
    check("ackall_ack", 32'(fifo_ack_v_o), 1);
    check("ackall_deq", 32'(fifo_deq_v_o), 0);
    check("ackall_link_v", 32'(link_v_o), 0);
    tick(); drive(1, 1, 0, 0, 0); #2;
    check("ackall_out_after", 32'(outstanding_o), 0);
    check("ackall_ack_clear", 32'(fifo_ack_v_o), 0);
    check("ackall_resume", 32'(fifo_yumi_o), 1);

    // Nack with 2 outstanding.
    tick(); #2;
    check("pre_nack_out1", 32'(outstanding_o), 1);
    tick(); drive(1, 1, 1, 1, 0); #2;
    check("pre_nack_out2", 32'(outstanding_o), 2);
    check("nack_link_v", 32'(link_v_o), 0);
    check("nack_rb_not_yet", 32'(fifo_rollback_v_o), 0);
    check("nack_deq", 32'(fifo_deq_v_o), 0);
    tick(); drive(1, 1, 0, 0, 0); #2;
    check("rb_pulse", 32'(fifo_rollback_v_o), 1);
    check("rb_out", 32'(outstanding_o), 0);
    check("rb_link_v", 32'(link_v_o), 0);
    check("rb_deq", 32'(fifo_deq_v_o), 0);
    check("rb_ack", 32'(fifo_ack_v_o), 0);
    check("rb_err", 32'(error_o), 0);
    tick(); #2;
    check("rb_done", 32'(fifo_rollback_v_o), 0);
    check("resend_yumi", 32'(fifo_yumi_o), 1);
    check("stats_1", 32'(rollback_cnt_o), exp_cnt(1));

    // Ack-all clears the retry budget before the timeout runs.
    tick(); drive(1, 1, 1, 0, 1); #2;
    check("clr_ack", 32'(fifo_ack_v_o), 1);
    tick(); drive(1, 1, 0, 0, 0); #2;

    // Three silent windows: each rewinds 17 cycles after its first read.
    for (int r = 0; r < retries_lp; r++) begin
      check("to_start_yumi", 32'(fifo_yumi_o), 1);
      check("to_start_out", 32'(outstanding_o), 0);
      found = 1'b0;
      n = 0;
      for (int i = 1; i <= 40 && !found; i++) begin
        tick(); #2;
        if (fifo_rollback_v_o) begin
          found = 1'b1;
          n = i;
        end
      end
      check("timeout_latency", 32'(n), 17);
      check("timeout_err_during_rb", 32'(error_o), 0);
      tick(); #2;
      if (r == 0) check("stats_2", 32'(rollback_cnt_o), exp_cnt(2));
    end

    // Retries exhausted: sticky error, outputs idle, responses ignored.
    check("err_set", 32'(error_o), 1);
    check_quiet("err");
    drive(1, 1, 1, 0, 1); #1;
    check("err_ack_ignored", 32'(fifo_ack_v_o), 0);
    for (int i = 0; i < 5; i++) begin
      tick(); #2;
      check("err_sticky", 32'(error_o), 1);
      check("err_link_v", 32'(link_v_o), 0);
    end
    check("stats_4", 32'(rollback_cnt_o), exp_cnt(4));

    // Reset recovers; then reset asserted in the middle of a rollback cycle.
    drive(1, 1, 0, 0, 0);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #2;
    check("rst_err_clear", 32'(error_o), 0);
    check("rst_cnt_clear", 32'(rollback_cnt_o), 0);
    check("rst_yumi", 32'(fifo_yumi_o), 1);
    tick(); drive(1, 1, 1, 1, 0); #2;
    check("rst_nack_out", 32'(outstanding_o), 1);
    tick(); drive(1, 1, 0, 0, 0); #2;
    check("mid_rb_pulse", 32'(fifo_rollback_v_o), 1);
    #1 reset_i = 1'b1;
    #1;
    check_quiet("mid_rb_reset");
    check("mid_rb_reset_err", 32'(error_o), 0);
    check("mid_rb_reset_cnt", 32'(rollback_cnt_o), 0);
    tick();
    reset_i = 1'b0;
    #2;
    check("post_rst_rb", 32'(fifo_rollback_v_o), 0);
    check("post_rst_yumi", 32'(fifo_yumi_o), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
